// File: rtl/serializer_stream.sv
// ---------------------------------------------------------------------------
// serializer_stream
//
// Parallel-to-serial converter. Words arrive through a valid/ready handshake.
// They are shifted out one bit per clock, with no idle bits between
// consecutive words. Each word carries its own length (1..WIDTH bits) and its
// own bit order. A one-word holding buffer sits behind the active shifter.
// The buffer lets the next word be accepted while the current one is still
// being sent. The buffered word then drops into the shifter on the same edge
// that the current word finishes.
//
// A word whose length is outside 1..WIDTH is still accepted, so the source
// never stalls on it. The word itself is thrown away, and err_len_o pulses for
// one cycle.
//
// Ports:
//   clk_i            : clock, all state changes on the rising edge
//   rst_n_i          : asynchronous reset, active-low
//   data_i           : parallel word (WIDTH bits)
//   data_mod_i       : number of bits to send from data_i (CNT_W bits)
//   data_lsb_first_i : 1 = send data_i[0] first, 0 = send data_i[WIDTH-1] first
//   data_val_i       : source has a word on data_i
//   data_rdy_o       : block accepts a word this cycle (holding buffer empty)
//   ser_data_o       : serial bit, forced to 0 when no bit is being sent
//   ser_data_val_o   : ser_data_o carries a bit this cycle
//   ser_last_o       : current bit is the final bit of its word
//   busy_o           : a word sits in the shifter or the holding buffer
//   err_len_o        : one-cycle pulse after a word with an illegal length
// ---------------------------------------------------------------------------
module serializer_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [CNT_W-1:0] data_mod_i,
  input  logic             data_lsb_first_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             ser_last_o,
  output logic             busy_o,
  output logic             err_len_o
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Active shifter. The bit on the wire is always at a fixed end of sh_data:
  // the MSB for MSB-first words and the LSB for LSB-first words. The register
  // therefore shifts toward that end.
  logic [WIDTH-1:0] sh_data;
  logic [CNT_W-1:0] sh_cnt;
  logic             sh_lsb;
  logic             sh_vld;

  // Holding buffer
  logic [WIDTH-1:0] pend_data;
  logic [CNT_W-1:0] pend_len;
  logic             pend_lsb;
  logic             pend_vld;

  logic             err_len;

  // Handshake and routing decisions
  logic             xfer;
  logic             len_ok;
  logic             sh_done;
  logic             sh_free;
  logic             load_sh;
  logic             load_pend;
  logic             cur_bit;

  // Decode the handshake and decide where an accepted word goes.
  // sh_free covers two cases. In the first, the shifter is idle. In the second,
  // the shifter is on its last bit and nothing is buffered, so the incoming
  // word can take the shifter's place directly. That direct path is what lets
  // back-to-back length-1 words run at one word per cycle.
  always_comb begin
    xfer      = 1'b0;
    len_ok    = 1'b0;
    sh_done   = 1'b0;
    sh_free   = 1'b0;
    load_sh   = 1'b0;
    load_pend = 1'b0;

    xfer      = data_val_i && !pend_vld;
    len_ok    = (data_mod_i != '0) && (data_mod_i <= MAX_LEN);
    sh_done   = sh_vld && (sh_cnt == ONE);
    sh_free   = !sh_vld || (sh_done && !pend_vld);
    load_sh   = xfer && len_ok && sh_free;
    load_pend = xfer && len_ok && !sh_free;
  end

  // Pick the bit currently on the wire from the end that matches the word's order.
  always_comb begin
    cur_bit = 1'b0;
    if (sh_lsb) begin
      cur_bit = sh_data[0];
    end else begin
      cur_bit = sh_data[WIDTH-1];
    end
  end

  // Shifter. A direct load takes priority. It can only happen when the
  // holding buffer is empty, so it never competes with a refill from the buffer.
  // When the last bit finishes, the buffered word (if any) is moved in on the
  // same edge, so the wire never sees a gap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_data <= '0;
      sh_cnt  <= '0;
      sh_lsb  <= 1'b0;
      sh_vld  <= 1'b0;
    end else if (load_sh) begin
      sh_data <= data_i;
      sh_cnt  <= data_mod_i;
      sh_lsb  <= data_lsb_first_i;
      sh_vld  <= 1'b1;
    end else if (sh_done) begin
      if (pend_vld) begin
        sh_data <= pend_data;
        sh_cnt  <= pend_len;
        sh_lsb  <= pend_lsb;
        sh_vld  <= 1'b1;
      end else begin
        sh_cnt  <= '0;
        sh_vld  <= 1'b0;
      end
    end else if (sh_vld) begin
      if (sh_lsb) begin
        sh_data <= {1'b0, sh_data[WIDTH-1:1]};
      end else begin
        sh_data <= {sh_data[WIDTH-2:0], 1'b0};
      end
      sh_cnt <= sh_cnt - ONE;
    end
  end

  // Holding buffer. The buffer only accepts a word while it is empty, because
  // data_rdy_o is low otherwise. So a capture and a hand-off to the shifter
  // can never happen on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_data <= '0;
      pend_len  <= '0;
      pend_lsb  <= 1'b0;
      pend_vld  <= 1'b0;
    end else if (load_pend) begin
      pend_data <= data_i;
      pend_len  <= data_mod_i;
      pend_lsb  <= data_lsb_first_i;
      pend_vld  <= 1'b1;
    end else if (sh_done && pend_vld) begin
      pend_vld  <= 1'b0;
    end
  end

  // A dropped word leaves the shifter and the buffer untouched. The only trace
  // it leaves is this one-cycle flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_len <= 1'b0;
    end else begin
      err_len <= xfer && !len_ok;
    end
  end

  assign data_rdy_o     = !pend_vld;
  assign ser_data_val_o = sh_vld;
  assign ser_data_o     = sh_vld && cur_bit;
  assign ser_last_o     = sh_done;
  assign busy_o         = sh_vld || pend_vld;
  assign err_len_o      = err_len;

endmodule

// File: tb/tb_serializer_stream.sv
// ---------------------------------------------------------------------------
// tb_serializer_stream
//
// Self-checking bench for serializer_stream (WIDTH=16).
//
// The reference model is a queue of {bit, last} pairs. Each word the DUT
// accepts is expanded into its bits and appended to the queue. One entry is
// retired per clock while the queue is non-empty. From this queue alone the
// model derives:
//   - the output bit and the last-bit flag (the head entry),
//   - the valid flag (queue not empty),
//   - ready (at most one word is queued),
//   - busy.
// Inputs change on the falling edge, and outputs are checked on the next
// falling edge.
// ---------------------------------------------------------------------------
module tb_serializer_stream;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [CNT_W-1:0] data_mod_i = '0;
  logic             data_lsb_first_i = 1'b0;
  logic             data_val_i = 1'b0;
  logic             data_rdy_o;
  logic             ser_data_o;
  logic             ser_data_val_o;
  logic             ser_last_o;
  logic             busy_o;
  logic             err_len_o;

  int               total_checks = 0;
  int               bad_checks = 0;

  // Model state
  logic [1:0]       exp_q[$];
  logic             err_exp = 1'b0;
  logic             blocked = 1'b0;
  logic [31:0]      capture = '0;

  serializer_stream #(.WIDTH(WIDTH)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .data_i           (data_i),
    .data_mod_i       (data_mod_i),
    .data_lsb_first_i (data_lsb_first_i),
    .data_val_i       (data_val_i),
    .data_rdy_o       (data_rdy_o),
    .ser_data_o       (ser_data_o),
    .ser_data_val_o   (ser_data_val_o),
    .ser_last_o       (ser_last_o),
    .busy_o           (busy_o),
    .err_len_o        (err_len_o)
  );

  always #5 clk_i = ~clk_i;

  // Words still owed to the wire: one last-bit marker per word.
  function automatic int wordsQueued();
    int n;
    n = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i][0]) n++;
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic checkCycle();
    logic has_bit;
    has_bit = (exp_q.size() > 0);
    checkOutput("ser_val", 32'(ser_data_val_o), 32'(has_bit));
    checkOutput("ser_data", 32'(ser_data_o), has_bit ? 32'(exp_q[0][1]) : 32'd0);
    checkOutput("ser_last", 32'(ser_last_o), has_bit ? 32'(exp_q[0][0]) : 32'd0);
    checkOutput("busy", 32'(busy_o), 32'(has_bit));
    checkOutput("ready", 32'(data_rdy_o), 32'(wordsQueued() <= 1));
    checkOutput("err_len", 32'(err_len_o), 32'(err_exp));
    if (ser_data_val_o) capture = {capture[30:0], ser_data_o};
  endtask

  // Drive one cycle of input, advance the model across the edge, then check.
  task automatic applyStimulus(input logic val, input logic [WIDTH-1:0] data,
                               input logic [CNT_W-1:0] len, input logic lsb);
    logic xfer;
    int   l;
    data_val_i       = val;
    data_i           = data;
    data_mod_i       = len;
    data_lsb_first_i = lsb;
    l       = int'(len);
    xfer    = val && (wordsQueued() <= 1);
    blocked = val && !xfer;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    err_exp = xfer && (l == 0 || l > WIDTH);
    if (xfer && l >= 1 && l <= WIDTH) begin
      for (int i = 0; i < l; i++) begin
        exp_q.push_back({(lsb ? data[i] : data[WIDTH-1-i]), (i == l - 1)});
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    checkCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic             v;
    logic [CNT_W-1:0] len;
    int               r;

    // Reset state while rst_n_i is held low
    @(negedge clk_i);
    checkOutput("rst_ready", 32'(data_rdy_o), 32'd1);
    checkOutput("rst_val", 32'(ser_data_val_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_err", 32'(err_len_o), 32'd0);
    rst_n_i = 1'b1;

    $display("[TB] single 16-bit word, MSB-first");
    capture = '0;
    applyStimulus(1'b1, 16'hA5C3, CNT_W'(16), 1'b0);
    idle(17);
    checkOutput("t1_bits", capture & 32'hFFFF, 32'h0000A5C3);

    $display("[TB] LSB-first 4-bit word");
    capture = '0;
    applyStimulus(1'b1, 16'h000B, CNT_W'(4), 1'b1);
    idle(5);
    checkOutput("t2_bits", capture & 32'hF, 32'hD);

    $display("[TB] back-to-back words");
    capture = '0;
    applyStimulus(1'b1, 16'hE000, CNT_W'(3), 1'b0);
    applyStimulus(1'b1, 16'h0015, CNT_W'(5), 1'b1);
    idle(9);
    checkOutput("t3_bits", capture & 32'hFF, 32'hF5);

    $display("[TB] length-1 streaming");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, WIDTH'($urandom), CNT_W'(1), 1'($urandom));
    idle(2);

    $display("[TB] illegal lengths");
    applyStimulus(1'b1, WIDTH'($urandom), CNT_W'(0), 1'b0);
    applyStimulus(1'b1, WIDTH'($urandom), CNT_W'(17), 1'b0);
    idle(2);
    checkOutput("t5_busy", 32'(busy_o), 32'd0);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, WIDTH'($urandom), CNT_W'(16), 1'b0);
    applyStimulus(1'b1, WIDTH'($urandom), CNT_W'(16), 1'b1);
    idle(3);
    checkOutput("t6_pending", 32'(data_rdy_o), 32'd0);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("t6_async_val", 32'(ser_data_val_o), 32'd0);
    checkOutput("t6_async_data", 32'(ser_data_o), 32'd0);
    checkOutput("t6_async_last", 32'(ser_last_o), 32'd0);
    checkOutput("t6_async_busy", 32'(busy_o), 32'd0);
    checkOutput("t6_async_ready", 32'(data_rdy_o), 32'd1);
    exp_q.delete();
    err_exp = 1'b0;
    blocked = 1'b0;
    @(negedge clk_i);
    checkCycle();
    rst_n_i = 1'b1;
    idle(20);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      if (blocked) begin
        applyStimulus(data_val_i, data_i, data_mod_i, data_lsb_first_i);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 19);
        if (r == 0) len = '0;
        else if (r == 1) len = CNT_W'($urandom_range(17, 31));
        else if (r < 8) len = CNT_W'($urandom_range(1, 3));
        else len = CNT_W'($urandom_range(1, 16));
        applyStimulus(v, WIDTH'($urandom), len, 1'($urandom));
      end
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
Parallel-to-serial converter with a valid/ready input handshake and a one-word holding buffer, so consecutive words stream with no idle bits between them. Per-word length is 1..WIDTH bits, and bit order is selectable per word. Invalid lengths are consumed and flagged instead of silently ignored. It sits between word-oriented datapath logic and a 1-bit serial link, and a downstream framer uses ser_last_o as a word delimiter.

Parameters:
WIDTH, 16, parallel word width in bits; must be >= 2.
CNT_W, $clog2(WIDTH)+1, width of the length field and internal bit counter (derived; do not override).

Ports:
clk_i  input  1  clock; all logic is on the rising edge.
rst_n_i  input  1  asynchronous reset, active-low.
data_i  input  WIDTH  parallel word.
data_mod_i  input  CNT_W  number of bits to transmit; valid range 1..WIDTH.
data_lsb_first_i  input  1  0 = MSB-first, 1 = LSB-first; sampled with the word.
data_val_i  input  1  word valid.
data_rdy_o  output  1  block can accept a word this cycle.
ser_data_o  output  1  serial bit.
ser_data_val_o  output  1  ser_data_o carries a bit.
ser_last_o  output  1  current bit is the final bit of its word.
busy_o  output  1  a word is in the shifter or the holding buffer.
err_len_o  output  1  one-cycle pulse: a word with an illegal length was dropped.

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous and active-low.
- State:
  - Active shifter: shift register, bit counter (CNT_W bits), order flag, valid flag.
  - Holding buffer: word, length, order flag, valid flag (pend_vld).
- Reset: all valid flags, counters and err_len_o clear immediately, without waiting for a clock edge.
  - While rst_n_i is low: ser_data_o=0, ser_data_val_o=0, ser_last_o=0, busy_o=0, err_len_o=0, data_rdy_o=1.
  - Reset mid-word aborts the word and discards the buffer, with no partial completion.
- Handshake:
  - data_rdy_o = !pend_vld, derived from registered state only, never from data_val_i.
  - A transfer occurs on a rising edge where data_val_i && data_rdy_o.
  - The source must hold data_i, data_mod_i and data_lsb_first_i stable while data_val_i=1 && data_rdy_o=0.
- Length check:
  - data_mod_i==0 or data_mod_i>WIDTH: the transfer completes, the word is discarded, and err_len_o=1 for exactly the next cycle.
  - Shifter and buffer contents are unaffected by a dropped word.
- Load routing at a transfer edge:
  - Shifter empty, or shifter on its last bit with pend_vld=0: the word loads directly into the shifter (bypass).
  - Otherwise: the word loads into the holding buffer.
- Completion: at the edge where the shifter finishes its last bit, a pending word moves into the shifter and pend_vld clears. Serial output has no gap.
- Latency: a word accepted at edge k drives its first bit during the cycle after edge k, provided the shifter was free.
- Throughput: one bit per cycle sustained, including back-to-back length-1 words (one word per cycle).
- Bit order for a word of length L:
  - MSB-first: data_i[WIDTH-1], data_i[WIDTH-2], ..., data_i[WIDTH-L].
  - LSB-first: data_i[0], data_i[1], ..., data_i[L-1].
- Outputs:
  - ser_data_val_o = shifter valid.
  - ser_data_o = current bit when valid, else 0.
  - ser_last_o = valid && counter==1.
  - busy_o = shifter valid || pend_vld.
  - All outputs are functions of registers only; there is no combinational path from any input to any output.
- Counter: loaded with L and decremented once per emitted bit. It never wraps; the word ends at 1 and the shifter becomes empty (or reloads).
- Simultaneous events: a transfer and shifter completion at the same edge follow the routing rules above. No word may be lost or duplicated.

Test Plan:
- Single word, MSB-first: data_i=16'hA5C3, data_mod_i=16. Expect bits 1010010111000011 over 16 consecutive cycles, ser_last_o on the 16th only, then busy_o=0.
- LSB-first short word: data_i=16'h000B, data_mod_i=4, data_lsb_first_i=1. Expect bits 1,1,0,1 with ser_last_o on the 4th, and data_rdy_o high throughout.
- Back-to-back words:
  - Word A: 16'hE000, len 3, MSB-first. Word B: 16'h0015, len 5, LSB-first.
  - data_val_i is held high for both.
  - Expect 8 contiguous valid bits 1,1,1,1,0,1,0,1, with ser_last_o on bits 3 and 8.
  - data_rdy_o low while B is buffered.
- Length-1 streaming: 8 words, data_mod_i=1, data_val_i held high. Expect ready always high, one word accepted per cycle, ser_data_val_o and ser_last_o high for 8 consecutive cycles.
- Illegal lengths: data_mod_i=0, then 17, each with data_val_i=1. Expect both accepted (data_rdy_o=1), an err_len_o pulse one cycle after each, no ser_data_val_o, and busy_o=0.
- Reset mid-operation: assert rst_n_i=0 asynchronously (between edges) during bit 5 of a 16-bit word with another word pending. Expect all outputs to go 0 (data_rdy_o=1) before the next edge. After release, no residual bits are emitted.
